// File: rtl/display_scan_driver.sv
// Four-digit multiplexed seven-segment driver. It shadows the BCD digits once per
// frame, scans one digit at a time, and can blink, blank a leading zero and show a colon.
module display_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] segment_0,
  input  logic [3:0] segment_1,
  input  logic [3:0] segment_2,
  input  logic [3:0] segment_3,
  input  logic       blink_en,
  input  logic       colon_en,
  input  logic       blank_lz,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [SW-1:0]     scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              scan_wrap, blink_wrap, frame_load, blanked;
  logic [3:0]        digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
  always_comb begin
    scan_wrap     = (scan_q == SW'(SCAN_DIV - 1));
    scan_d        = scan_wrap ? '0 : scan_q + SW'(1);
    idx_d         = scan_wrap ? idx_q + 2'd1 : idx_q;

    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;

    // The digit loaded at frame start is the one shown in that same cycle.
    frame_load    = (scan_q == '0) && (idx_q == 2'd0);
    shadow_d      = frame_load ? {segment_3, segment_2, segment_1, segment_0} : shadow_q;
    digit         = shadow_d[idx_q];

    blanked       = blink_en && blink_phase_q;

    anode_d = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!blanked) begin
      anode_d = ~(4'b0001 << idx_q);
      if (!(idx_q == 2'd3 && blank_lz && digit == 4'd0))
        seg_d = decode(digit);
      dp_d = !(idx_q == 2'd2 && colon_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q        <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= '0;
      anode_q       <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      scan_q        <= scan_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with SCAN_DIV=4, BLINK_DIV=64.
// After k rising edges past reset release, outputs reflect index ((k-1)/4)%4.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] segment_0, segment_1, segment_2, segment_3;
  logic       blink_en, colon_en, blank_lz;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .clk(clk), .reset(reset),
    .segment_0(segment_0), .segment_1(segment_1),
    .segment_2(segment_2), .segment_3(segment_3),
    .blink_en(blink_en), .colon_en(colon_en), .blank_lz(blank_lz),
    .anode(anode), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] s3, s2, s1, s0;
    logic       blink, colon, blz;
    int         k;
    logic [3:0] exp_anode;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    check({name, ".anode"}, 16'(anode), 16'(a));
    check({name, ".seg"},   16'(seg),   16'(s));
    check({name, ".dp"},    16'(dp),    16'(d));
  endtask

  // Drives inputs, holds reset two cycles (checking the reset outputs), then releases.
  task automatic restart(input logic [3:0] s3, s2, s1, s0, input logic bl, co, lz);
    segment_3 = s3; segment_2 = s2; segment_1 = s1; segment_0 = s0;
    blink_en = bl; colon_en = co; blank_lz = lz;
    reset = 1'b1;
    step(2);
    check_out("reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] s3, s2, s1, s0,
                              input logic bl, co, lz, input int k,
                              input logic [3:0] a, input logic [6:0] s, input logic d);
    vec_t v;
    v.name = nm; v.s3 = s3; v.s2 = s2; v.s1 = s1; v.s0 = s0;
    v.blink = bl; v.colon = co; v.blz = lz; v.k = k;
    v.exp_anode = a; v.exp_seg = s; v.exp_dp = d;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    {segment_3, segment_2, segment_1, segment_0} = '0;
    {blink_en, colon_en, blank_lz} = '0;

    // Basic scan of 1,2,3,4 including wrap back to digit 0
    vecs.push_back(mk("scan_k1",  1,2,3,4, 0,0,0,  1, 4'hE, 7'h19, 1));
    vecs.push_back(mk("scan_k4",  1,2,3,4, 0,0,0,  4, 4'hE, 7'h19, 1));
    vecs.push_back(mk("scan_k5",  1,2,3,4, 0,0,0,  5, 4'hD, 7'h30, 1));
    vecs.push_back(mk("scan_k9",  1,2,3,4, 0,0,0,  9, 4'hB, 7'h24, 1));
    vecs.push_back(mk("scan_k13", 1,2,3,4, 0,0,0, 13, 4'h7, 7'h79, 1));
    vecs.push_back(mk("scan_k17", 1,2,3,4, 0,0,0, 17, 4'hE, 7'h19, 1));
    // Remaining decoder entries
    vecs.push_back(mk("dec5", 8,7,6,5, 0,0,0,  1, 4'hE, 7'h12, 1));
    vecs.push_back(mk("dec6", 8,7,6,5, 0,0,0,  5, 4'hD, 7'h02, 1));
    vecs.push_back(mk("dec7", 8,7,6,5, 0,0,0,  9, 4'hB, 7'h78, 1));
    vecs.push_back(mk("dec8", 8,7,6,5, 0,0,0, 13, 4'h7, 7'h00, 1));
    vecs.push_back(mk("dec9", 0,0,0,9, 0,0,0,  1, 4'hE, 7'h10, 1));
    vecs.push_back(mk("dec15", 0,0,0,15, 0,0,0, 1, 4'hE, 7'h7F, 1));
    vecs.push_back(mk("dec12_d1", 1,2,12,4, 0,0,0, 5, 4'hD, 7'h7F, 1));
    // Leading-zero blanking on digit 3 only
    vecs.push_back(mk("lz_on",  0,2,3,4, 0,0,1, 13, 4'h7, 7'h7F, 1));
    vecs.push_back(mk("lz_off", 0,2,3,4, 0,0,0, 13, 4'h7, 7'h40, 1));
    vecs.push_back(mk("lz_d0",  1,2,3,0, 0,0,1,  1, 4'hE, 7'h40, 1));
    // Colon only on digit 2
    vecs.push_back(mk("colon_d1", 1,2,3,4, 0,1,0,  5, 4'hD, 7'h30, 1));
    vecs.push_back(mk("colon_d2", 1,2,3,4, 0,1,0,  9, 4'hB, 7'h24, 0));
    vecs.push_back(mk("colon_d3", 1,2,3,4, 0,1,0, 13, 4'h7, 7'h79, 1));
    // Blink: visible for output cycles 1..64, blank for 65..128, visible again after
    vecs.push_back(mk("blink_k64",  1,2,3,4, 1,0,0,  64, 4'h7, 7'h79, 1));
    vecs.push_back(mk("blink_k65",  1,2,3,4, 1,0,0,  65, 4'hF, 7'h7F, 1));
    vecs.push_back(mk("blink_k73",  1,2,3,4, 1,1,0,  73, 4'hF, 7'h7F, 1));
    vecs.push_back(mk("blink_k128", 1,2,3,4, 1,0,0, 128, 4'hF, 7'h7F, 1));
    vecs.push_back(mk("blink_k129", 1,2,3,4, 1,0,0, 129, 4'hE, 7'h19, 1));
    vecs.push_back(mk("blink_k137", 1,2,3,4, 1,1,0, 137, 4'hB, 7'h24, 0));
    // Blink counter runs while blink_en=0; enabling it mid-phase blanks at once
    vecs.push_back(mk("noblink_k65", 1,2,3,4, 0,0,0, 65, 4'hE, 7'h19, 1));

    foreach (vecs[i]) begin
      restart(vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0,
              vecs[i].blink, vecs[i].colon, vecs[i].blz);
      step(vecs[i].k);
      check_out(vecs[i].name, vecs[i].exp_anode, vecs[i].exp_seg, vecs[i].exp_dp);
    end

    // Late blink enable: phase is already 1 at cycle 70, outputs blank one cycle later
    restart(1, 2, 3, 4, 0, 0, 0);
    step(70);
    blink_en = 1'b1;
    step(1);
    check_out("late_blink", 4'hF, 7'h7F, 1'b1);
    blink_en = 1'b0;
    step(1);
    check_out("late_unblink", 4'hD, 7'h30, 1'b1);

    // Shadowing: a mid-frame change to segment_0 waits for the next frame start
    restart(1, 2, 3, 4, 0, 0, 0);
    step(1);
    check_out("shadow_k1", 4'hE, 7'h19, 1'b1);
    segment_0 = 4'd9;
    step(3);
    check_out("shadow_k4", 4'hE, 7'h19, 1'b1);
    step(5);
    segment_0 = 4'd4;
    step(1);
    segment_0 = 4'd9;
    step(7);
    check_out("shadow_k17", 4'hE, 7'h10, 1'b1);

    // Reset at index 2 blanks on the next edge; scan restarts at digit 0
    restart(1, 2, 3, 4, 0, 1, 0);
    step(10);
    check_out("pre_rst_d2", 4'hB, 7'h24, 1'b0);
    reset = 1'b1;
    step(1);
    check_out("mid_rst", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
    step(1);
    check_out("post_rst_k1", 4'hE, 7'h19, 1'b1);
    step(4);
    check_out("post_rst_k5", 4'hD, 7'h30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit is driven (minimum 2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have ports segment_0 to segment_3, input, 4 each, meaning BCD digits, with segment_0 the rightmost (minutes ones) and segment_3 the leftmost (hours tens).
REQ-006 SHALL have port blink_en, input, 1, meaning blink the whole display (alarm ringing or set mode).
REQ-007 SHALL have port colon_en, input, 1, meaning light the colon decimal point on digit 2.
REQ-008 SHALL have port blank_lz, input, 1, meaning blank a leading zero on digit 3.
REQ-009 SHALL have port anode, output, 4, meaning active-low digit enables, with bit i selecting digit i.
REQ-010 SHALL have port seg, output, 7, meaning active-low cathodes {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1, meaning active-low decimal point.

Function
REQ-012 SHALL hold a scan counter that runs 0..SCAN_DIV-1 and wraps to 0.
REQ-013 SHALL hold a 2-bit digit index that advances 0->1->2->3->0, one step in each cycle where the scan counter equals SCAN_DIV-1.
REQ-014 SHALL load all four segment_x inputs into shadow registers in each cycle where the scan counter is 0 and the index is 0 (frame start), so a frame never mixes old and new digits.
REQ-015 SHALL register anode, seg and dp with 1-cycle latency: the outputs in cycle t+1 reflect the index and shadow value in effect in cycle t, and the value loaded in a load cycle is the one in effect for that cycle.
REQ-016 SHALL drive exactly one anode bit low (bit = index) when the display is not blanked, and all four anode bits high when blanked.
REQ-017 SHALL decode digits to seg as 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-018 SHALL drive seg=0x7F (segments off) for digit values 10-15, while the anode is still asserted.
REQ-019 SHALL drive seg=0x7F on digit 3 when blank_lz=1 and the digit 3 shadow value is 0; other digits are never zero-blanked.
REQ-020 SHALL drive dp=0 only when the index is 2, colon_en=1 and the display is not blanked; otherwise dp=1.
REQ-021 SHALL hold a blink counter that runs 0..BLINK_DIV-1, toggles blink_phase at wrap, and runs regardless of blink_en.
REQ-022 SHALL blank the display (anode=0xF, seg=0x7F, dp=1) when blink_en=1 and blink_phase=1, while the scan and index keep advancing.
REQ-023 SHALL sample blink_en, colon_en and blank_lz every cycle; they are not shadowed.

Reset
REQ-024 SHALL set, while reset=1: anode=0xF, seg=0x7F, dp=1, scan counter=0, index=0, blink counter=0, blink_phase=0, shadows=0.
REQ-025 SHALL treat the first cycle after reset is released as a frame-start load cycle.
REQ-026 SHALL apply a reset asserted mid-frame on the next edge, discarding the partial frame.

Verification (SCAN_DIV=4, BLINK_DIV=64)
REQ-027 SHALL cover: segments 3,2,1,0 = 1,2,3,4 and reset released -> anode steps 0xE,0xD,0xB,0x7 every 4 cycles with seg 0x19,0x30,0x24,0x79, then repeats.
REQ-028 SHALL cover: segment_0 changes 4->9 while index=2 -> digit 0 keeps showing 0x19 until the next frame start, then shows 0x10.
REQ-029 SHALL cover: segment_3=0 with blank_lz=1 -> digit 3 shows anode=0x7, seg=0x7F; with blank_lz=0 -> seg=0x40; segment_1=12 -> seg=0x7F.
REQ-030 SHALL cover: colon_en=1 -> dp=0 only in cycles where anode=0xB.
REQ-031 SHALL cover: blink_en=1 -> outputs normal for 64 cycles, then anode=0xF, seg=0x7F, dp=1 for 64 cycles, and the index continues advancing throughout.
REQ-032 SHALL cover: reset asserted at index=2 -> next cycle anode=0xF, seg=0x7F, dp=1; after release, the scan restarts at digit 0.
